main_mem_tester: RTL and testbench

MAIN_MEM_TESTER -- requirements
Module: main_mem_tester

---
 rtl/main_mem_tester.sv | 233 +++++++++++++++++++++++
 tb/tb_main_mem_tester.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_mem_tester.sv
// main_mem_tester: Wishbone master that tests a block of memory in two passes.
// It writes one pattern word per address, then reads every word back and
// compares it. Word k holds seed + k*0x01010101 and sits at byte address
// base + 4k. Mismatches and bus errors are counted. A transfer that gets no
// response within TIMEOUT cycles aborts the run.
//
// Optional feature (macro AMBER_MEMTEST_INV_PASS_EN): after the read pass,
// a third pass writes and checks the bitwise-inverted pattern at the same
// addresses, using the INV_WRITE and INV_READ states.
//
// Ports:
//   i_clk, i_rst_n                  clock, asynchronous active-low reset
//   i_start                         one-cycle run request (accepted in IDLE only)
//   i_base_adr, i_num_words, i_seed run parameters, latched on start
//   o_busy, o_done, o_pass          run status (o_done sticky until next start)
//   o_timeout                       run aborted because a transfer got no response
//   o_err_count, o_first_err_adr    error count (saturating) and first failing address
//   o_wb_*                          Wishbone master request
//   i_wb_dat, i_wb_ack, i_wb_err    Wishbone master response
module main_mem_tester #(
    parameter int WB_DWIDTH = 32,
    parameter int WB_SWIDTH = 4,
    parameter int TIMEOUT   = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [31:0]          i_base_adr,
    input  logic [15:0]          i_num_words,
    input  logic [31:0]          i_seed,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic                 o_timeout,
    output logic [15:0]          o_err_count,
    output logic [31:0]          o_first_err_adr,
    output logic [31:0]          o_wb_adr,
    output logic [WB_SWIDTH-1:0] o_wb_sel,
    output logic                 o_wb_we,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    input  logic                 i_wb_ack,
    input  logic                 i_wb_err
);

`ifdef AMBER_MEMTEST_INV_PASS_EN
    typedef enum logic [2:0] {IDLE, WRITE, READ, INV_WRITE, INV_READ, FINISH} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;
`endif

    localparam logic [31:0] PAT_STEP  = 32'h0101_0101;
    // The wait counter starts at 0 in the first request cycle, so stb stays
    // high for exactly TIMEOUT cycles before a timeout abort.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    logic [31:0] base_reg;
    logic [31:0] seed_reg;
    logic [31:0] pat_reg;     // running pattern accumulator, replaces k*step
    logic [15:0] num_reg;
    logic [15:0] word_cnt;
    logic [15:0] wait_cnt;
    logic        err_seen;    // first-error address already captured

    logic        phase_we;
    logic        phase_inv;
    state_t      after_phase;
    logic [31:0] expect_dat;
    logic        xfer_end;
    logic        err_now;
    logic        last_word;

    always_comb begin
        phase_we    = 1'b0;
        phase_inv   = 1'b0;
        after_phase = FINISH;
        case (state)
            WRITE: begin
                phase_we    = 1'b1;
                after_phase = READ;
            end
            READ: begin
`ifdef AMBER_MEMTEST_INV_PASS_EN
                after_phase = INV_WRITE;
`else
                after_phase = FINISH;
`endif
            end
`ifdef AMBER_MEMTEST_INV_PASS_EN
            INV_WRITE: begin
                phase_we    = 1'b1;
                phase_inv   = 1'b1;
                after_phase = INV_READ;
            end
            INV_READ: begin
                phase_inv   = 1'b1;
                after_phase = FINISH;
            end
`endif
            default: ;
        endcase
        expect_dat = phase_inv ? ~pat_reg : pat_reg;
        xfer_end   = o_wb_stb & (i_wb_ack | i_wb_err);
        // err has priority over ack; a read compare only happens on a clean ack.
        err_now    = o_wb_stb & (i_wb_err |
                     (i_wb_ack & ~phase_we & (i_wb_dat != expect_dat)));
        last_word  = (word_cnt == num_reg - 16'd1);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            base_reg        <= '0;
            seed_reg        <= '0;
            pat_reg         <= '0;
            num_reg         <= '0;
            word_cnt        <= '0;
            wait_cnt        <= '0;
            err_seen        <= 1'b0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_pass          <= 1'b0;
            o_timeout       <= 1'b0;
            o_err_count     <= '0;
            o_first_err_adr <= '0;
            o_wb_adr        <= '0;
            o_wb_sel        <= '0;
            o_wb_we         <= 1'b0;
            o_wb_dat        <= '0;
            o_wb_cyc        <= 1'b0;
            o_wb_stb        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        base_reg        <= i_base_adr & ~32'h3;
                        seed_reg        <= i_seed;
                        num_reg         <= i_num_words;
                        pat_reg         <= i_seed;
                        word_cnt        <= '0;
                        wait_cnt        <= '0;
                        err_seen        <= 1'b0;
                        o_timeout       <= 1'b0;
                        o_err_count     <= '0;
                        o_first_err_adr <= '0;
                        if (i_num_words == 16'd0) begin
                            state  <= FINISH;
                            o_done <= 1'b1;
                            o_pass <= 1'b1;
                        end else begin
                            // The first write request goes out right away.
                            state    <= WRITE;
                            o_done   <= 1'b0;
                            o_pass   <= 1'b0;
                            o_busy   <= 1'b1;
                            o_wb_cyc <= 1'b1;
                            o_wb_stb <= 1'b1;
                            o_wb_we  <= 1'b1;
                            o_wb_sel <= {WB_SWIDTH{1'b1}};
                            o_wb_adr <= i_base_adr & ~32'h3;
                            o_wb_dat <= i_seed;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    if (o_wb_stb) begin
                        if (xfer_end) begin
                            // stb drops for one cycle after every transfer.
                            o_wb_stb <= 1'b0;
                            wait_cnt <= '0;
                            if (err_now) begin
                                if (o_err_count != 16'hFFFF)
                                    o_err_count <= o_err_count + 16'd1;
                                if (!err_seen)
                                    o_first_err_adr <= o_wb_adr;
                                err_seen <= 1'b1;
                            end
                            if (last_word) begin
                                word_cnt <= '0;
                                pat_reg  <= seed_reg;
                                o_wb_adr <= base_reg;
                                state    <= after_phase;
                                if (after_phase == FINISH) begin
                                    o_wb_cyc <= 1'b0;
                                    o_wb_we  <= 1'b0;
                                    o_wb_sel <= '0;
                                    o_wb_dat <= '0;
                                    o_busy   <= 1'b0;
                                    o_done   <= 1'b1;
                                    o_pass   <= ~(err_seen | err_now);
                                end
                            end else begin
                                word_cnt <= word_cnt + 16'd1;
                                pat_reg  <= pat_reg + PAT_STEP;
                                o_wb_adr <= o_wb_adr + 32'd4;
                            end
                        end else if (wait_cnt == WAIT_LAST) begin
                            o_wb_stb  <= 1'b0;
                            o_wb_cyc  <= 1'b0;
                            o_wb_we   <= 1'b0;
                            o_wb_sel  <= '0;
                            o_wb_dat  <= '0;
                            o_busy    <= 1'b0;
                            o_timeout <= 1'b1;
                            o_pass    <= 1'b0;
                            o_done    <= 1'b1;
                            state     <= FINISH;
                            if (!err_seen)
                                o_first_err_adr <= o_wb_adr;
                            err_seen  <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 16'd1;
                        end
                    end else begin
                        // Gap cycle: present the next request. The address and
                        // pattern were already advanced on the previous ack.
                        o_wb_stb <= 1'b1;
                        o_wb_we  <= phase_we;
                        o_wb_sel <= {WB_SWIDTH{1'b1}};
                        o_wb_dat <= phase_we ? expect_dat : '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_main_mem_tester.sv
// Testbench for main_mem_tester: table of directed runs against a behavioural
// Wishbone slave, plus hand-written sequences for full pattern contents,
// reset in the middle of a read, and start requests while busy.
module tb_main_mem_tester;

`ifdef AMBER_MEMTEST_INV_PASS_EN
    localparam int PASSES = 4;
`else
    localparam int PASSES = 2;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [31:0] i_base_adr;
    logic [15:0] i_num_words;
    logic [31:0] i_seed;
    logic        o_busy, o_done, o_pass, o_timeout;
    logic [15:0] o_err_count;
    logic [31:0] o_first_err_adr;
    logic [31:0] o_wb_adr;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we, o_wb_cyc, o_wb_stb;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack, i_wb_err;

    always #5 i_clk = ~i_clk;

    main_mem_tester #(.WB_DWIDTH(32), .WB_SWIDTH(4), .TIMEOUT(8)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start),
        .i_base_adr(i_base_adr), .i_num_words(i_num_words), .i_seed(i_seed),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
        .o_err_count(o_err_count), .o_first_err_adr(o_first_err_adr),
        .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_dat(o_wb_dat), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
        .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
    );

    // ---------------- behavioural slave ----------------
    int          rd_lat = 0, wr_lat = 0;
    logic        never_ack = 1'b0, cor_en = 1'b0, err_en = 1'b0;
    logic [31:0] cor_adr = '0, err_adr = '0;
    int          cor_base = 0, err_base = 0;
    int          lat_cnt = 0, cor_hits = 0, err_hits = 0;
    logic [31:0] mem [0:255];
    logic        lat_hit, cor_now;

    assign lat_hit  = o_wb_stb && o_wb_cyc && !never_ack &&
                      (lat_cnt == (o_wb_we ? wr_lat : rd_lat));
    assign i_wb_ack = lat_hit;
    assign i_wb_err = lat_hit && err_en && o_wb_we && (o_wb_adr == err_adr) &&
                      (err_hits == err_base);
    assign cor_now  = cor_en && !o_wb_we && (o_wb_adr == cor_adr) &&
                      (cor_hits == cor_base);
    assign i_wb_dat = mem[o_wb_adr[9:2]] ^ {31'b0, cor_now};

    always @(posedge i_clk) begin
        if (o_wb_stb && !i_wb_ack) lat_cnt <= lat_cnt + 1;
        else                       lat_cnt <= 0;
        if (i_wb_ack && o_wb_we)   mem[o_wb_adr[9:2]] <= o_wb_dat;
        if (i_wb_err)              err_hits <= err_hits + 1;
        if (i_wb_ack && cor_now)   cor_hits <= cor_hits + 1;
    end

    // ---------------- bus monitor ----------------
    int          xfer_n = 0, stb_total = 0, gap_bad = 0, gap_cnt = 0, stb_no_cyc = 0;
    logic        prev_stb = 1'b0, prev_cyc = 1'b0;
    logic [31:0] log_adr [0:255];
    logic [31:0] log_dat [0:255];
    logic        log_we  [0:255];

    always @(negedge i_clk) begin
        prev_stb <= o_wb_stb;
        prev_cyc <= o_wb_cyc;
        if (o_wb_stb) begin
            stb_total <= stb_total + 1;
            gap_cnt   <= 0;
        end else if (o_wb_cyc) begin
            gap_cnt <= gap_cnt + 1;
        end
        if (o_wb_stb && !prev_stb && prev_cyc && gap_cnt != 1) gap_bad <= gap_bad + 1;
        if (o_wb_stb && !o_wb_cyc) stb_no_cyc <= stb_no_cyc + 1;
        if (o_wb_stb && (i_wb_ack || i_wb_err)) begin
            if (xfer_n < 256) begin
                log_adr[xfer_n] <= o_wb_adr;
                log_dat[xfer_n] <= o_wb_we ? o_wb_dat : i_wb_dat;
                log_we[xfer_n]  <= o_wb_we;
            end
            xfer_n <= xfer_n + 1;
            $display("xfer %0d we=%0b adr=%h dat=%h ack=%0b err=%0b", xfer_n, o_wb_we,
                     o_wb_adr, o_wb_we ? o_wb_dat : i_wb_dat, i_wb_ack, i_wb_err);
        end
    end

    logic any_out;
    assign any_out = |{o_busy, o_done, o_pass, o_timeout, o_err_count, o_first_err_adr,
                       o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, o_wb_cyc, o_wb_stb};

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [31:0] base;
        logic [15:0] num;
        logic [31:0] seed;
        logic [3:0]  rlat;
        logic [3:0]  wlat;
        logic        never;
        logic        cor_en;
        logic [31:0] cor_adr;
        logic        err_en;
        logic [31:0] err_adr;
        logic        e_pass;
        logic [15:0] e_cnt;
        logic        e_to;
        logic [31:0] e_first;
        logic [15:0] e_xfers;
        logic [15:0] e_stb;     // 16'hFFFF: not checked
        logic [31:0] e_wadr0;
        logic [31:0] e_wdat0;
        logic [31:0] e_wadr1;
        logic [31:0] e_wdat1;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_slave(input vec_t v);
        rd_lat    = int'(v.rlat);
        wr_lat    = int'(v.wlat);
        never_ack = v.never;
        cor_en    = v.cor_en;
        cor_adr   = v.cor_adr;
        err_en    = v.err_en;
        err_adr   = v.err_adr;
        cor_base  = cor_hits;
        err_base  = err_hits;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
        @(negedge i_clk);
        i_base_adr  = b;
        i_num_words = n;
        i_seed      = s;
        i_start     = 1'b1;
        @(negedge i_clk);
        i_start     = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!o_done && cyc < 3000) begin
            @(negedge i_clk);
            cyc++;
        end
        chk("done_wait", {31'b0, o_done}, 32'd1);
        #1;
    endtask

    initial begin
        int   x0, st0, g0, cyc, n;
        vec_t rv;
        i_rst_n = 1'b0; i_start = 1'b0;
        i_base_adr = '0; i_num_words = '0; i_seed = '0;

        //         base          num    seed          rl wl nv ce cadr         ee eadr         pass cnt to first          xfers              stb       wadr0         wdat0         wadr1         wdat1
        vecs[0] = '{32'h100,     16'd4, 32'h11223344, 4'd0, 4'd0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 16'd0, 1'b0, 32'h0,   16'(PASSES*4),  16'hFFFF, 32'h100,      32'h11223344, 32'h104, 32'h12233445};
        vecs[1] = '{32'h200,     16'd16, 32'hA5A50000, 4'd3, 4'd0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0,   1'b1, 16'd0, 1'b0, 32'h0,   16'(PASSES*16), 16'hFFFF, 32'h200,      32'hA5A50000, 32'h204, 32'hA6A60101};
        vecs[2] = '{32'h100,     16'd4, 32'h11223344, 4'd0, 4'd0, 1'b0, 1'b1, 32'h108, 1'b0, 32'h0,   1'b0, 16'd1, 1'b0, 32'h108, 16'(PASSES*4),  16'hFFFF, 32'h100,      32'h11223344, 32'h104, 32'h12233445};
        vecs[3] = '{32'h100,     16'd4, 32'h11223344, 4'd0, 4'd0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 16'd1, 1'b0, 32'h104, 16'(PASSES*4),  16'hFFFF, 32'h100,      32'h11223344, 32'h104, 32'h12233445};
        vecs[4] = '{32'h40,      16'd4, 32'h0,        4'd0, 4'd0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 16'd0, 1'b1, 32'h40,  16'd0,          16'd8,    32'h0,        32'h0,        32'h0,   32'h0};
        vecs[5] = '{32'h500,     16'd0, 32'h12345678, 4'd0, 4'd0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 16'd0, 1'b0, 32'h0,   16'd0,          16'd0,    32'h0,        32'h0,        32'h0,   32'h0};
        vecs[6] = '{32'hFFFFFFFC, 16'd2, 32'h1,       4'd0, 4'd0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 16'd0, 1'b0, 32'h0,   16'(PASSES*2),  16'hFFFF, 32'hFFFFFFFC, 32'h1,        32'h0,   32'h01010102};
        vecs[7] = '{32'h303,     16'd1, 32'hDEADBEEF, 4'd1, 4'd2, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 16'd0, 1'b0, 32'h0,   16'(PASSES*1),  16'hFFFF, 32'h300,      32'hDEADBEEF, 32'h0,   32'h0};

        repeat (3) @(negedge i_clk);
        chk("reset_state", {31'b0, any_out}, 32'd0);
        i_rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            set_slave(vecs[i]);
            x0  = xfer_n;
            st0 = stb_total;
            g0  = gap_bad;
            pulse_start(vecs[i].base, vecs[i].num, vecs[i].seed);
            wait_done(cyc);
            $display("vec %0d base=%h num=%0d pass=%0b cnt=%0d to=%0b first=%h xfers=%0d cycles=%0d",
                     i, vecs[i].base, vecs[i].num, o_pass, o_err_count, o_timeout,
                     o_first_err_adr, xfer_n - x0, cyc);
            chk($sformatf("v%0d_pass", i), {31'b0, o_pass}, {31'b0, vecs[i].e_pass});
            chk($sformatf("v%0d_err_count", i), {16'b0, o_err_count}, {16'b0, vecs[i].e_cnt});
            chk($sformatf("v%0d_timeout", i), {31'b0, o_timeout}, {31'b0, vecs[i].e_to});
            chk($sformatf("v%0d_first_err", i), o_first_err_adr, vecs[i].e_first);
            chk($sformatf("v%0d_xfers", i), 32'(xfer_n - x0), {16'b0, vecs[i].e_xfers});
            chk($sformatf("v%0d_gap", i), 32'(gap_bad - g0), 32'd0);
            chk($sformatf("v%0d_idle_bus", i), {29'b0, o_busy, o_wb_cyc, o_wb_stb}, 32'd0);
            if (vecs[i].e_stb != 16'hFFFF)
                chk($sformatf("v%0d_stb_cycles", i), 32'(stb_total - st0), {16'b0, vecs[i].e_stb});
            if (vecs[i].num == 16'd0)
                chk($sformatf("v%0d_done_latency", i), 32'(cyc), 32'd0);
            if (vecs[i].e_xfers >= 16'd1) begin
                chk($sformatf("v%0d_wadr0", i), log_adr[x0], vecs[i].e_wadr0);
                chk($sformatf("v%0d_wdat0", i), log_dat[x0], vecs[i].e_wdat0);
                chk($sformatf("v%0d_rd_adr0", i), log_adr[x0 + int'(vecs[i].num)], vecs[i].e_wadr0);
                chk($sformatf("v%0d_rd_we", i), {31'b0, log_we[x0 + int'(vecs[i].num)]}, 32'd0);
            end
            if (vecs[i].e_xfers >= 16'd2 && vecs[i].num >= 16'd2) begin
                chk($sformatf("v%0d_wadr1", i), log_adr[x0 + 1], vecs[i].e_wadr1);
                chk($sformatf("v%0d_wdat1", i), log_dat[x0 + 1], vecs[i].e_wdat1);
            end
        end

        // Full write contents of the normal run.
        set_slave(vecs[0]);
        x0 = xfer_n;
        pulse_start(32'h100, 16'd4, 32'h11223344);
        wait_done(cyc);
        chk("normal_wdat2", log_dat[x0 + 2], 32'h13243546);
        chk("normal_wadr2", log_adr[x0 + 2], 32'h108);
        chk("normal_wdat3", log_dat[x0 + 3], 32'h14253647);
        chk("normal_wadr3", log_adr[x0 + 3], 32'h10C);
`ifdef AMBER_MEMTEST_INV_PASS_EN
        chk("inv_wdat0", log_dat[x0 + 8], 32'hEEDDCCBB);
        chk("inv_we0", {31'b0, log_we[x0 + 8]}, 32'd1);
`endif

        // Reset while the read of word 2 is in progress.
        rv      = vecs[0];
        rv.rlat = 4'd3;
        set_slave(rv);
        pulse_start(32'h100, 16'd4, 32'h11223344);
        n = 0;
        while (!(o_wb_stb && !o_wb_we && o_wb_adr == 32'h108) && n < 500) begin
            @(negedge i_clk);
            n++;
        end
        chk("reach_read_word2", {31'b0, (n < 500)}, 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_cyc_stb", {30'b0, o_wb_cyc, o_wb_stb}, 32'd0);
        chk("rst_all_outputs", {31'b0, any_out}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // First start after reset, with a second start while busy that must be ignored.
        x0 = xfer_n;
        pulse_start(32'h100, 16'd4, 32'h11223344);
        repeat (3) @(negedge i_clk);
        pulse_start(32'h900, 16'd0, 32'h0);
        wait_done(cyc);
        $display("post-reset run pass=%0b cnt=%0d xfers=%0d", o_pass, o_err_count, xfer_n - x0);
        chk("post_rst_pass", {31'b0, o_pass}, 32'd1);
        chk("post_rst_err_count", {16'b0, o_err_count}, 32'd0);
        chk("post_rst_xfers", 32'(xfer_n - x0), 32'(PASSES * 4));
        chk("busy_start_ignored_adr", log_adr[x0 + 3], 32'h10C);

        chk("stb_without_cyc", 32'(stb_no_cyc), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
